// File: rtl/sync_fifo_status_pkg.sv
// Shared sizing defaults, status-flag bit positions and pointer helpers for sync_fifo_status.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sync_fifo_status_pkg;

  localparam int unsigned DATA_SIZE_DEF = 4;
  localparam int unsigned ADDR_SIZE_DEF = 4;

  // Bit positions inside the registered status-flag vector
  localparam int unsigned FLAG_FULL   = 0;
  localparam int unsigned FLAG_EMPTY  = 1;
  localparam int unsigned FLAG_AFULL  = 2;
  localparam int unsigned FLAG_AEMPTY = 3;
  localparam int unsigned FLAG_NUM    = 4;

  function automatic int unsigned depth_of(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

  // Full when only the wrap bit differs between the two pointers
  function automatic logic ptr_full(input logic [31:0] wp, input logic [31:0] rp,
                                    input int unsigned addr_size);
    return (wp ^ rp) == (32'd1 << addr_size);
  endfunction

  function automatic logic ptr_empty(input logic [31:0] wp, input logic [31:0] rp);
    return wp == rp;
  endfunction

endpackage

// File: rtl/sync_fifo_status_if.sv
// Producer/consumer-facing bundle of the single-clock status FIFO.
// Latency: n/a (wiring only).
// Backpressure: full/empty tell the producer/consumer when requests would be rejected.
interface sync_fifo_status_if
  import sync_fifo_status_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
);
  logic                 wr_en;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 rd_en;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 rd_valid;
  logic                 full;
  logic                 empty;
  logic                 almost_full;
  logic                 almost_empty;
  logic [ADDR_SIZE:0]   afull_thresh;
  logic [ADDR_SIZE:0]   aempty_thresh;
  logic [ADDR_SIZE:0]   count;
  logic                 overflow;
  logic                 underflow;
  logic                 err_clr;

  // Producer/consumer side
  modport master (
    output wr_en, wr_data, rd_en, afull_thresh, aempty_thresh, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  // FIFO side
  modport slave (
    input  wr_en, wr_data, rd_en, afull_thresh, aempty_thresh, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_status_mem.sv
// Storage array for sync_fifo_status: one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller only asserts wr_en for accepted writes.
module sync_fifo_status_mem
  import sync_fifo_status_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_SIZE-1:0] wr_addr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic [ADDR_SIZE-1:0] rd_addr,
  output logic [DATA_SIZE-1:0] rd_data
);
  localparam int unsigned DEPTH = depth_of(ADDR_SIZE);

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // Contents are deliberately not reset; pointers define what is valid
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/sync_fifo_status.sv
// Single-clock FIFO with occupancy count, programmable almost-full/empty, sticky overflow/underflow.
// Latency: read data 1 cycle after accepted rd_en; 0 (head word shown) when SYNC_FIFO_FWFT_EN is defined.
// Backpressure: writes while full and reads while empty are dropped and flagged; no stall signalling.
module sync_fifo_status
  import sync_fifo_status_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  sync_fifo_status_if.slave   bus
);
  typedef logic [ADDR_SIZE:0] ptr_t;

  ptr_t                 wr_ptr, rd_ptr;
  ptr_t                 wr_ptr_nxt, rd_ptr_nxt;
  ptr_t                 count_nxt, count_q;
  logic [FLAG_NUM-1:0]  flags_q, flags_nxt;
  logic                 wr_acc, rd_acc;
  logic                 overflow_q, underflow_q;
  logic [DATA_SIZE-1:0] mem_rd_data;

  // Acceptance uses the registered flags, so a same-cycle pop never makes room for a write
  // (and a same-cycle push never supplies data for a read).
  always_comb begin
    wr_acc     = bus.wr_en && !flags_q[FLAG_FULL];
    rd_acc     = bus.rd_en && !flags_q[FLAG_EMPTY];
    wr_ptr_nxt = wr_ptr + ptr_t'(wr_acc);
    rd_ptr_nxt = rd_ptr + ptr_t'(rd_acc);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    flags_nxt              = '0;
    flags_nxt[FLAG_FULL]   = ptr_full(32'(wr_ptr_nxt), 32'(rd_ptr_nxt), ADDR_SIZE);
    flags_nxt[FLAG_EMPTY]  = ptr_empty(32'(wr_ptr_nxt), 32'(rd_ptr_nxt));
    flags_nxt[FLAG_AFULL]  = count_nxt >= bus.afull_thresh;
    flags_nxt[FLAG_AEMPTY] = count_nxt <= bus.aempty_thresh;
  end

  // Pointers, count and flags all register next-state values so status tracks the pointers with no lag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      count_q              <= '0;
      flags_q              <= '0;
      flags_q[FLAG_EMPTY]  <= 1'b1;
      flags_q[FLAG_AEMPTY] <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      count_q <= count_nxt;
      flags_q <= flags_nxt;
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clr wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && flags_q[FLAG_FULL])       overflow_q <= 1'b1;
      else if (bus.err_clr)                      overflow_q <= 1'b0;
      if (bus.rd_en && flags_q[FLAG_EMPTY])      underflow_q <= 1'b1;
      else if (bus.err_clr)                      underflow_q <= 1'b0;
    end
  end

  sync_fifo_status_mem #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc && rst_n),
    .wr_addr (wr_ptr[ADDR_SIZE-1:0]),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr[ADDR_SIZE-1:0]),
    .rd_data (mem_rd_data)
  );

`ifdef SYNC_FIFO_FWFT_EN
  // Head word is always presented; rd_en just acknowledges it
  assign bus.rd_data  = mem_rd_data;
  assign bus.rd_valid = !flags_q[FLAG_EMPTY];
`else
  logic [DATA_SIZE-1:0] rd_data_q;
  logic                 rd_valid_q;

  // Registered read stage: data captured on the accepting edge, valid for exactly one cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= mem_rd_data;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = flags_q[FLAG_FULL];
  assign bus.empty        = flags_q[FLAG_EMPTY];
  assign bus.almost_full  = flags_q[FLAG_AFULL];
  assign bus.almost_empty = flags_q[FLAG_AEMPTY];
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_status.sv
// Scoreboard bench for sync_fifo_status: queue-based reference model, directed scenarios then random traffic.
// Latency: checks read data 1 cycle after rd_en (standard) or same cycle (SYNC_FIFO_FWFT_EN).
// Backpressure: exercises writes while full and reads while empty.
module tb_sync_fifo_status;
  localparam int DW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_status_if #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) bus();

  sync_fifo_status #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] sb_q[$];   // expected popped words, consumed by the monitor
  logic [DW-1:0] m_q[$];    // reference FIFO contents
  bit            m_ov = 1'b0;
  bit            m_un = 1'b0;
  int            afth = 14;
  int            aeth = 2;
  logic [DW-1:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; model updated from the rules, status compared after the edge
  task automatic cycle(input bit rst, input bit wr, input logic [DW-1:0] wd,
                       input bit rd, input bit clr);
    int n;
    bit wa, ra;
    @(negedge clk);
    rst_n              = !rst;
    bus.wr_en          = wr;
    bus.wr_data        = wd;
    bus.rd_en          = rd;
    bus.err_clr        = clr;
    bus.afull_thresh   = 5'(afth);
    bus.aempty_thresh  = 5'(aeth);
    n  = m_q.size();
    wa = !rst && wr && (n < DEPTH);
    ra = !rst && rd && (n > 0);
    if (ra) sb_q.push_back(m_q[0]);
    @(posedge clk);
    #1;
    if (rst) begin
      m_q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (ra) void'(m_q.pop_front());
      if (wa) m_q.push_back(wd);
      m_ov = (wr && n == DEPTH) ? 1'b1 : (clr ? 1'b0 : m_ov);
      m_un = (rd && n == 0)     ? 1'b1 : (clr ? 1'b0 : m_un);
    end
    n = m_q.size();
    chk("count",        32'(bus.count),        32'(n));
    chk("full",         32'(bus.full),         32'(n == DEPTH));
    chk("empty",        32'(bus.empty),        32'(n == 0));
    chk("almost_full",  32'(bus.almost_full),  rst ? 32'd0 : 32'(n >= afth));
    chk("almost_empty", 32'(bus.almost_empty), rst ? 32'd1 : 32'(n <= aeth));
    chk("overflow",     32'(bus.overflow),     32'(m_ov));
    chk("underflow",    32'(bus.underflow),    32'(m_un));
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents read data
  initial begin
    logic [DW-1:0] e;
    forever begin
`ifdef SYNC_FIFO_FWFT_EN
      @(negedge clk);
      #2;
      if (rst_n && bus.rd_en) begin
        chk("rd_valid_fwft", 32'(bus.rd_valid), 32'(sb_q.size() > 0));
        if (bus.rd_valid && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("rd_data_fwft", 32'(bus.rd_data), 32'(e));
        end
      end
`else
      @(posedge clk);
      #2;
      if (!rst_n) last_rd = '0;
      chk("rd_valid", 32'(bus.rd_valid), 32'(sb_q.size() > 0));
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        last_rd = e;
      end
      chk("rd_data", 32'(bus.rd_data), 32'(last_rd));
`endif
    end
  end

  initial begin
    bus.wr_en         = 1'b0;
    bus.wr_data       = '0;
    bus.rd_en         = 1'b0;
    bus.err_clr       = 1'b0;
    bus.afull_thresh  = 5'd14;
    bus.aempty_thresh = 5'd2;

    // Reset held two cycles with a write request pending
    cycle(1, 1, 4'hA, 0, 0);
    cycle(1, 1, 4'hA, 0, 0);

    // Fill with 1..F then E, then one write too many
    afth = 14;
    aeth = 2;
    for (int i = 0; i < 16; i++) cycle(0, 1, (i < 15) ? 4'(i + 1) : 4'hE, 0, 0);
    cycle(0, 1, 4'h7, 0, 0);

    // Error clear, then clear racing a fresh overflow
    cycle(0, 0, 4'h0, 0, 1);
    cycle(0, 1, 4'h7, 0, 0);
    cycle(0, 1, 4'h7, 0, 1);
    cycle(0, 0, 4'h0, 0, 1);

    // Drain all sixteen, then one read too many
    for (int k = 0; k < 40 && m_q.size() > 0; k++) cycle(0, 0, 4'h0, 1, 0);
    cycle(0, 0, 4'h0, 1, 0);
    cycle(0, 0, 4'h0, 0, 1);

    // Empty with both requests: only the write lands
    cycle(0, 1, 4'h3, 1, 0);

    // Refill, then full with both requests: only the read lands
    for (int k = 0; k < 40 && m_q.size() < DEPTH; k++) cycle(0, 1, 4'($urandom()), 0, 0);
    cycle(0, 1, 4'h9, 1, 0);

    // Down to eight, then sustained simultaneous traffic across pointer wrap
    for (int k = 0; k < 40 && m_q.size() > 8; k++) cycle(0, 0, 4'h0, 1, 0);
    for (int k = 0; k < 20; k++) cycle(0, 1, 4'($urandom()), 1, 0);

    // Random traffic with occasional threshold changes and mid-run resets
    for (int k = 0; k < 400; k++) begin
      if (k % 32 == 0) begin
        afth = $urandom_range(0, 16);
        aeth = $urandom_range(0, 16);
      end
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 55, 4'($urandom()),
            $urandom_range(0, 99) < 50, $urandom_range(0, 15) == 0);
    end

    for (int k = 0; k < 40 && m_q.size() > 0; k++) cycle(0, 0, 4'h0, 1, 0);
    repeat (3) cycle(0, 0, 4'h0, 0, 0);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
